// File: rtl/omux_rr_arbiter.sv
// Round-robin arbiter that grants one internal writer at a time onto the shared
// outgoing byte path, holding each captured byte until the host side acks it.
module omux_rr_arbiter #(
  parameter int N_SRCS    = 2,
  parameter int MAX_BURST = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        omux_data_i,
  input  logic [N_SRCS-1:0] omux_req_i,
  output logic [N_SRCS-1:0] omux_sel_o,
  output logic [7:0]        out_o,
  output logic              out_req_o,
  input  logic              out_ack_i,
  output logic              busy_o,
  output logic [31:0]       byte_count_o
);

  localparam int SRC_W = (N_SRCS > 1) ? $clog2(N_SRCS) : 1;
  localparam int BURST_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRCS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    SEND
  } state_t;

  state_t             state, state_next;
  logic [SRC_W-1:0]   cur, cur_next;
  logic [SRC_W-1:0]   last_grant, last_grant_next;
  logic [SRC_W-1:0]   rr_pick;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_next;
  logic [7:0]         out_next;
  logic [31:0]        count_next;
  logic               req_cur;
  logic               burst_done;
  logic               rr_found;

  assign req_cur = omux_req_i[cur];
  assign burst_done = (MAX_BURST != 0) && (burst_cnt == BURST_LIMIT);

  // Scan starts one past the previous grant so every writer gets its turn.
  always_comb begin
    rr_pick  = last_grant;
    rr_found = 1'b0;
    for (int i = 1; i <= N_SRCS; i++) begin
      if (!rr_found && omux_req_i[(int'(last_grant) + i) % N_SRCS]) begin
        rr_pick  = SRC_W'((int'(last_grant) + i) % N_SRCS);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    cur_next        = cur;
    last_grant_next = last_grant;
    burst_cnt_next  = burst_cnt;
    out_next        = out_o;
    count_next      = byte_count_o;
    omux_sel_o      = '0;
    out_req_o       = 1'b0;
    busy_o          = (state != IDLE);

    case (state)
      IDLE: begin
        if (omux_req_i != '0) begin
          cur_next       = rr_pick;
          burst_cnt_next = '0;
          state_next     = SEL;
        end
      end
      SEL: begin
        if (req_cur) begin
          omux_sel_o     = N_SRCS'(1) << cur;
          out_next       = omux_data_i;
          burst_cnt_next = burst_cnt + 1'b1;
          state_next     = SEND;
        end else begin
          last_grant_next = cur;
          state_next      = IDLE;
        end
      end
      SEND: begin
        out_req_o = 1'b1;
        if (out_ack_i) begin
          count_next = byte_count_o + 32'd1;
          if (burst_done || !req_cur) begin
            last_grant_next = cur;
            state_next      = IDLE;
          end else begin
            state_next = SEL;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cur          <= '0;
      last_grant   <= LAST_SRC;
      burst_cnt    <= '0;
      out_o        <= 8'h00;
      byte_count_o <= 32'd0;
    end else begin
      state        <= state_next;
      cur          <= cur_next;
      last_grant   <= last_grant_next;
      burst_cnt    <= burst_cnt_next;
      out_o        <= out_next;
      byte_count_o <= count_next;
    end
  end

endmodule

// File: tb/tb_omux_rr_arbiter.sv
// Directed bench for omux_rr_arbiter: a cycle table for the basic flows plus
// hand-written sequences for bursts, ack stalls, mid-transfer reset and unlimited mode.
module tb_omux_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  omux_data_i = 8'h00;
  logic [1:0]  omux_req_i = 2'b00;
  logic        out_ack_i = 1'b0;

  logic [1:0]  sel, sel_u;
  logic [7:0]  out, out_u;
  logic        oreq, oreq_u;
  logic        busy, busy_u;
  logic [31:0] count, count_u;

  int assert_cnt = 0;
  int fail_cnt = 0;

  always #5 clk_i = ~clk_i;

  omux_rr_arbiter #(.N_SRCS(2), .MAX_BURST(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .omux_data_i(omux_data_i), .omux_req_i(omux_req_i),
    .omux_sel_o(sel), .out_o(out), .out_req_o(oreq), .out_ack_i(out_ack_i),
    .busy_o(busy), .byte_count_o(count)
  );

  omux_rr_arbiter #(.N_SRCS(2), .MAX_BURST(0)) dut_u (
    .clk_i(clk_i), .reset_i(reset_i), .omux_data_i(omux_data_i), .omux_req_i(omux_req_i),
    .omux_sel_o(sel_u), .out_o(out_u), .out_req_o(oreq_u), .out_ack_i(out_ack_i),
    .busy_o(busy_u), .byte_count_o(count_u)
  );

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  data;
    logic        ack;
    logic [1:0]  sel;
    logic        oreq;
    logic [7:0]  out;
    logic        busy;
    logic [31:0] count;
  } vec_t;

  vec_t vecs[22];

  // Inputs change on the falling edge; outputs are read 1 ns later.
  task automatic applyStimulus(input logic rst, input logic [1:0] req,
                               input logic [7:0] data, input logic ack);
    @(negedge clk_i);
    reset_i     = rst;
    omux_req_i  = req;
    omux_data_i = data;
    out_ack_i   = ack;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] grants[12];
    int n;
    int strobes;
    int busy_gaps;
    logic [7:0] last_byte;

    vecs[0]  = '{2'b01, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 32'd0};
    vecs[1]  = '{2'b01, 8'hA1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 32'd0};
    vecs[2]  = '{2'b01, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA1, 1'b1, 32'd0};
    vecs[3]  = '{2'b01, 8'h00, 1'b1, 2'b00, 1'b1, 8'hA1, 1'b1, 32'd0};
    vecs[4]  = '{2'b01, 8'hA2, 1'b0, 2'b01, 1'b0, 8'hA1, 1'b1, 32'd1};
    vecs[5]  = '{2'b01, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA2, 1'b1, 32'd1};
    vecs[6]  = '{2'b01, 8'h00, 1'b1, 2'b00, 1'b1, 8'hA2, 1'b1, 32'd1};
    vecs[7]  = '{2'b01, 8'hA3, 1'b0, 2'b01, 1'b0, 8'hA2, 1'b1, 32'd2};
    vecs[8]  = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA3, 1'b1, 32'd2};
    vecs[9]  = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hA3, 1'b1, 32'd2};
    vecs[10] = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA3, 1'b0, 32'd3};
    vecs[11] = '{2'b10, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA3, 1'b0, 32'd3};
    vecs[12] = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA3, 1'b1, 32'd3};
    vecs[13] = '{2'b11, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA3, 1'b0, 32'd3};
    vecs[14] = '{2'b11, 8'hB0, 1'b0, 2'b01, 1'b0, 8'hA3, 1'b1, 32'd3};
    vecs[15] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hB0, 1'b1, 32'd3};
    vecs[16] = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 8'hB0, 1'b0, 32'd4};
    vecs[17] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'hB0, 1'b0, 32'd4};
    vecs[18] = '{2'b01, 8'h00, 1'b1, 2'b00, 1'b0, 8'hB0, 1'b0, 32'd4};
    vecs[19] = '{2'b01, 8'hC0, 1'b1, 2'b01, 1'b0, 8'hB0, 1'b1, 32'd4};
    vecs[20] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hC0, 1'b1, 32'd4};
    vecs[21] = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 8'hC0, 1'b0, 32'd5};

    $display("[TB] Start");
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0);

    // Single-writer flow, withdrawn request, rotation and stray acks
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, vecs[i].req, vecs[i].data, vecs[i].ack);
      checkOutput($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      checkOutput($sformatf("vec%0d_out_req", i), 32'(oreq), 32'(vecs[i].oreq));
      checkOutput($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].out));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_count", i), count, vecs[i].count);
    end

    // Burst limit of 4 with both writers requesting and immediate acks
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0);
    n = 0;
    for (int c = 0; c < 200 && n < 12; c++) begin
      applyStimulus(1'b0, 2'b11, 8'h11, 1'b1);
      checkOutput("burst_sel_req_exclusive", 32'((sel != 2'b00) && oreq), 32'd0);
      if (sel != 2'b00) begin
        grants[n] = sel;
        n++;
      end
    end
    checkOutput("burst_strobe_timeout", 32'(n), 32'd12);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("burst_grant%0d", i), 32'(grants[i]),
                  ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);

    // Ack stall: the captured byte must be held for as long as ack is low
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0);
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      applyStimulus(1'b0, 2'b01, 8'h3C, 1'b0);
      if (sel == 2'b01) n = 1;
    end
    checkOutput("stall_strobe_timeout", 32'(n), 32'd1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 2'b01, 8'hEE, 1'b0);
      checkOutput("stall_out_req", 32'(oreq), 32'd1);
      checkOutput("stall_out", 32'(out), 32'h3C);
      checkOutput("stall_sel", 32'(sel), 32'd0);
      checkOutput("stall_count", count, 32'd0);
    end
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("stall_ack_out_req", 32'(oreq), 32'd1);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
    checkOutput("stall_after_count", count, 32'd1);
    checkOutput("stall_after_busy", 32'(busy), 32'd0);

    // Reset while a byte is waiting in SEND
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 2'b10, 8'h00, 1'b0);
    applyStimulus(1'b0, 2'b10, 8'h5A, 1'b0);
    checkOutput("rst_pre_sel", 32'(sel), 32'd2);
    applyStimulus(1'b0, 2'b10, 8'h00, 1'b0);
    checkOutput("rst_pre_out", 32'(out), 32'h5A);
    checkOutput("rst_pre_out_req", 32'(oreq), 32'd1);
    applyStimulus(1'b1, 2'b10, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
    checkOutput("rst_out_req", 32'(oreq), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_count", count, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out", 32'(out), 32'h00);
    applyStimulus(1'b0, 2'b11, 8'h00, 1'b0);
    applyStimulus(1'b0, 2'b11, 8'h77, 1'b0);
    checkOutput("rst_next_grant", 32'(sel), 32'd1);

    // Unlimited burst: 300 bytes from writer 0 without leaving the grant
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0);
    strobes = 0;
    busy_gaps = 0;
    last_byte = 8'h00;
    for (int c = 0; c < 1000 && strobes < 300; c++) begin
      applyStimulus(1'b0, 2'b01, 8'(strobes + 1), 1'b1);
      if (strobes > 0 && !busy_u) busy_gaps++;
      if (sel_u == 2'b01) begin
        strobes++;
        last_byte = 8'(strobes);
      end
    end
    checkOutput("unl_strobe_timeout", 32'(strobes), 32'd300);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("unl_last_out", 32'(out_u), 32'(last_byte));
    checkOutput("unl_last_byte", 32'(out_u), 32'h2C);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
    checkOutput("unl_busy_gaps", 32'(busy_gaps), 32'd0);
    checkOutput("unl_count", count_u, 32'd300);
    checkOutput("unl_idle", 32'(busy_u), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
